switch_allocator_rr: RTL and testbench
======================================

Name: switch_allocator_rr

Overview:
- Separable input-first switch allocator for the router; sits between the input ports and the crossbar.
- Each cycle it selects at most one VC per input port and at most one input port per output port.
- Grants honour downstream on/off flow control.
- Results are registered and drive the input ports' sa_valid/sa_sel_vc inputs and the crossbar select lines.

Parameters:
- PORT_NUM, 5: number of input ports and number of output ports.
- VC_NUM, 2: virtual channels per port.
- VC_W, $clog2(VC_NUM) (min 1): width of a VC index.
- PORT_W, $clog2(PORT_NUM) (min 1): width of a port index.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- switch_request_i  input  PORT_NUM*VC_NUM  bit [ip*VC_NUM+v]: VC v of input port ip holds a flit ready to traverse.
- out_port_i  input  PORT_NUM*VC_NUM*PORT_W  routed output port of each requesting VC.
- downstream_vc_i  input  PORT_NUM*VC_NUM*VC_W  downstream VC allocated to each input VC.
- on_off_i  input  PORT_NUM*VC_NUM  bit [op*VC_NUM+d]: 1 = downstream VC d behind output op can accept a flit.
- valid_sel_o  output  PORT_NUM  input port ip wins this cycle.
- vc_sel_o  output  PORT_NUM*VC_W  winning VC of input port ip; 0 when not valid.
- xb_valid_o  output  PORT_NUM  output port op is driven this cycle.
- xb_sel_o  output  PORT_NUM*PORT_W  input port index routed to output op; 0 when not valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0.
  - All input-stage and output-stage round-robin pointers go to 0.
  - Takes effect immediately mid-operation; no grant is issued in the first edge after release unless requests are present at that edge.
- Eligibility (combinational):
  - VC (ip,v) is eligible iff switch_request_i[ip,v]=1, out_port_i[ip,v] < PORT_NUM, and on_off_i[out_port_i, downstream_vc_i]=1.
  - An out_port value >= PORT_NUM is treated as no request. This is not an error.
- Stage 1, per input port:
  - Round-robin arbiter over eligible VCs, starting search at in_ptr[ip].
  - Winner w1[ip]; port has a candidate iff any VC is eligible.
- Stage 2, per output port:
  - Round-robin arbiter over the input ports whose stage-1 winner targets op, starting search at out_ptr[op].
- Register stage, one cycle latency:
  - Stage-2 results are captured on the rising clk edge.
  - For each winning input port ip: valid_sel_o[ip]=1 and vc_sel_o[ip]=w1[ip].
  - For each output op with a winner: xb_valid_o[op]=1 and xb_sel_o[op]=ip.
  - Ports and outputs without a winner register 0.
- Pointer update, only on full grant (stage-2 win):
  - in_ptr[ip] <= (w1[ip]+1) mod VC_NUM.
  - out_ptr[op] <= (ip+1) mod PORT_NUM.
  - Losing stage 1 or stage 2 leaves the pointer unchanged.
  - Wrap-around: a pointer at VC_NUM-1 or PORT_NUM-1 goes to 0 after a grant.
- Invariants, every cycle:
  - At most one xb_valid_o per input index; at most one VC per input port.
  - sum(valid_sel_o) = sum(xb_valid_o).
- Flow control:
  - on_off_i is sampled in the same cycle as the request.
  - A VC whose target drops to off in cycle N is not granted in cycle N+1.
  - The allocator holds no credit state.
- No request anywhere: all outputs register 0 and pointers hold.
- Back-to-back grants to the same VC on consecutive cycles are permitted if it remains the only eligible requester.
- Fairness: with persistent contention, each of K competing requesters is granted exactly once every K grants of the contested resource.

Test Plan:
- Reset: hold rst=0 with all requests high -> all outputs 0. Release rst -> first grant appears one edge later with in_ptr/out_ptr=0, so input 0 VC 0 wins output 2 when all VCs target output 2.
- Single request: ip=3, v=1, out_port=4, downstream VC 0 on -> next cycle valid_sel_o[3]=1, vc_sel_o[3]=1, xb_valid_o[4]=1, xb_sel_o[4]=3; all other outputs 0.
- Output contention: ip 0,1,2 VC 0 all target output 1, persistent -> xb_sel_o[1] sequence 0,1,2,0 on consecutive cycles; the losers' valid_sel_o is 0 in each cycle.
- Input contention: ip 2 VCs 0 and 1 both eligible, to outputs 0 and 3 -> vc_sel_o[2] alternates 0,1,0 and xb_valid_o alternates between outputs 0 and 3.
- Flow control: ip 1 VC 0 to output 2, downstream VC 1 with on_off low -> no grant. Raise on_off -> grant the next cycle. Drop it again -> grants stop one cycle later.
- Parallel and invalid: ip 0 to output 1 and ip 4 to output 0 simultaneously -> both granted in the same cycle. ip 2 with out_port=7 -> never granted.

Source files
------------

// File: rtl/switch_allocator_rr.sv
// switch_allocator_rr
//   Separable input-first switch allocator. Each input port first picks one
//   eligible VC with a round-robin arbiter. Each output port then picks one
//   of the input ports whose chosen VC targets it, again round-robin. The
//   winners are registered and drive the input ports' sa_valid/sa_sel_vc
//   inputs and the crossbar select lines.
//
// Ports
//   clk              : clock, rising edge
//   rst              : asynchronous reset, active-low
//   switch_request_i : [ip*VC_NUM+v] VC v of input ip has a flit ready
//   out_port_i       : routed output port per input VC (PORT_W each)
//   downstream_vc_i  : downstream VC per input VC (VC_W each)
//   on_off_i         : [op*VC_NUM+d] downstream VC d behind output op is on
//   valid_sel_o      : input port ip won this cycle
//   vc_sel_o         : winning VC per input port, 0 when not valid
//   xb_valid_o       : output port op is driven this cycle
//   xb_sel_o         : input port routed to output op, 0 when not valid
module switch_allocator_rr #(
    parameter int PORT_NUM = 5,
    parameter int VC_NUM   = 2,
    parameter int VC_W     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    parameter int PORT_W   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PORT_NUM*VC_NUM-1:0]        switch_request_i,
    input  logic [PORT_NUM*VC_NUM*PORT_W-1:0] out_port_i,
    input  logic [PORT_NUM*VC_NUM*VC_W-1:0]   downstream_vc_i,
    input  logic [PORT_NUM*VC_NUM-1:0]        on_off_i,
    output logic [PORT_NUM-1:0]               valid_sel_o,
    output logic [PORT_NUM*VC_W-1:0]          vc_sel_o,
    output logic [PORT_NUM-1:0]               xb_valid_o,
    output logic [PORT_NUM*PORT_W-1:0]        xb_sel_o
);

    // Round-robin search helper: (base + k) folded back into [0, n).
    // base < n and k < n always hold, so a single subtraction suffices.
    function automatic int wrap_add(input int base, input int k, input int n);
        int s;
        s = base + k;
        if (s >= n) s = s - n;
        return s;
    endfunction

    logic [PORT_W-1:0] req_op  [PORT_NUM][VC_NUM];
    logic [VC_W-1:0]   req_dvc [PORT_NUM][VC_NUM];
    logic [VC_NUM-1:0] elig    [PORT_NUM];

    logic [VC_W-1:0]   in_ptr  [PORT_NUM];
    logic [PORT_W-1:0] out_ptr [PORT_NUM];

    logic [PORT_NUM-1:0] cand;
    logic [VC_W-1:0]     w1     [PORT_NUM];
    logic [PORT_W-1:0]   w1_op  [PORT_NUM];

    logic [PORT_NUM-1:0] xb_win;
    logic [PORT_W-1:0]   xb_ip  [PORT_NUM];
    logic [PORT_NUM-1:0] in_win;

    logic [PORT_NUM-1:0]        valid_sel_p1;
    logic [PORT_NUM*VC_W-1:0]   vc_sel_p1;
    logic [PORT_NUM-1:0]        xb_valid_p1;
    logic [PORT_NUM*PORT_W-1:0] xb_sel_p1;

    // ---- eligibility: request, legal route, downstream VC switched on ----
    always_comb begin
        for (int ip = 0; ip < PORT_NUM; ip++) begin
            elig[ip] = '0;
            for (int v = 0; v < VC_NUM; v++) begin
                req_op[ip][v]  = out_port_i[(ip*VC_NUM+v)*PORT_W +: PORT_W];
                req_dvc[ip][v] = downstream_vc_i[(ip*VC_NUM+v)*VC_W +: VC_W];
                // Out-of-range routes are silently treated as no request.
                if (switch_request_i[ip*VC_NUM+v] &&
                    int'(req_op[ip][v]) < PORT_NUM &&
                    int'(req_dvc[ip][v]) < VC_NUM) begin
                    elig[ip][v] = on_off_i[int'(req_op[ip][v])*VC_NUM + int'(req_dvc[ip][v])];
                end
            end
        end
    end

    // ---- stage 1: per-input VC arbitration ----
    always_comb begin
        for (int ip = 0; ip < PORT_NUM; ip++) begin
            cand[ip]  = 1'b0;
            w1[ip]    = '0;
            for (int k = 0; k < VC_NUM; k++) begin
                if (!cand[ip] && elig[ip][wrap_add(int'(in_ptr[ip]), k, VC_NUM)]) begin
                    cand[ip] = 1'b1;
                    w1[ip]   = VC_W'(wrap_add(int'(in_ptr[ip]), k, VC_NUM));
                end
            end
            w1_op[ip] = req_op[ip][w1[ip]];
        end
    end

    // ---- stage 2: per-output input-port arbitration ----
    always_comb begin
        for (int op = 0; op < PORT_NUM; op++) begin
            xb_win[op] = 1'b0;
            xb_ip[op]  = '0;
            for (int k = 0; k < PORT_NUM; k++) begin
                if (!xb_win[op] &&
                    cand[wrap_add(int'(out_ptr[op]), k, PORT_NUM)] &&
                    int'(w1_op[wrap_add(int'(out_ptr[op]), k, PORT_NUM)]) == op) begin
                    xb_win[op] = 1'b1;
                    xb_ip[op]  = PORT_W'(wrap_add(int'(out_ptr[op]), k, PORT_NUM));
                end
            end
        end
    end

    // An input port is fully granted when some output chose it.
    always_comb begin
        for (int ip = 0; ip < PORT_NUM; ip++) begin
            in_win[ip] = 1'b0;
            for (int op = 0; op < PORT_NUM; op++) begin
                if (xb_win[op] && int'(xb_ip[op]) == ip) in_win[ip] = 1'b1;
            end
        end
    end

    // ---- register stage: grants and pointer updates ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_sel_p1 <= '0;
            vc_sel_p1    <= '0;
            xb_valid_p1  <= '0;
            xb_sel_p1    <= '0;
            for (int i = 0; i < PORT_NUM; i++) begin
                in_ptr[i]  <= '0;
                out_ptr[i] <= '0;
            end
        end else begin
            for (int ip = 0; ip < PORT_NUM; ip++) begin
                valid_sel_p1[ip]             <= in_win[ip];
                vc_sel_p1[ip*VC_W +: VC_W]   <= in_win[ip] ? w1[ip] : '0;
                // Pointers move only on a full grant; stage-1 losers keep theirs.
                if (in_win[ip]) in_ptr[ip] <= VC_W'(wrap_add(int'(w1[ip]), 1, VC_NUM));
            end
            for (int op = 0; op < PORT_NUM; op++) begin
                xb_valid_p1[op]                <= xb_win[op];
                xb_sel_p1[op*PORT_W +: PORT_W] <= xb_win[op] ? xb_ip[op] : '0;
                if (xb_win[op]) out_ptr[op] <= PORT_W'(wrap_add(int'(xb_ip[op]), 1, PORT_NUM));
            end
        end
    end

    assign valid_sel_o = valid_sel_p1;
    assign vc_sel_o    = vc_sel_p1;
    assign xb_valid_o  = xb_valid_p1;
    assign xb_sel_o    = xb_sel_p1;

endmodule

// File: tb/tb_switch_allocator_rr.sv
module tb_switch_allocator_rr;

    localparam int P  = 5;
    localparam int V  = 2;
    localparam int VW = 1;
    localparam int PW = 3;

    logic clk;
    logic rst;
    logic [P*V-1:0]    switch_request_i;
    logic [P*V*PW-1:0] out_port_i;
    logic [P*V*VW-1:0] downstream_vc_i;
    logic [P*V-1:0]    on_off_i;
    logic [P-1:0]      valid_sel_o;
    logic [P*VW-1:0]   vc_sel_o;
    logic [P-1:0]      xb_valid_o;
    logic [P*PW-1:0]   xb_sel_o;

    switch_allocator_rr #(.PORT_NUM(P), .VC_NUM(V)) dut (
        .clk(clk),
        .rst(rst),
        .switch_request_i(switch_request_i),
        .out_port_i(out_port_i),
        .downstream_vc_i(downstream_vc_i),
        .on_off_i(on_off_i),
        .valid_sel_o(valid_sel_o),
        .vc_sel_o(vc_sel_o),
        .xb_valid_o(xb_valid_o),
        .xb_sel_o(xb_sel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus as plain tables
    int req   [P][V];
    int oport [P][V];
    int dvc   [P][V];
    int onoff [P][V];

    // Reference model state
    int m_in_ptr  [P];
    int m_out_ptr [P];

    logic [P-1:0]    e_vsel;
    logic [P*VW-1:0] e_vc;
    logic [P-1:0]    e_xbv;
    logic [P*PW-1:0] e_xbs;

    int n_vec = 0;
    int n_miscmp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < P; i++)
            for (int v = 0; v < V; v++) begin
                req[i][v] = 0; oport[i][v] = 0; dvc[i][v] = 0; onoff[i][v] = 0;
            end
    endtask

    task automatic pack();
        for (int i = 0; i < P; i++)
            for (int v = 0; v < V; v++) begin
                switch_request_i[i*V+v]          = req[i][v][0];
                out_port_i[(i*V+v)*PW +: PW]     = oport[i][v][PW-1:0];
                downstream_vc_i[(i*V+v)*VW +: VW] = dvc[i][v][VW-1:0];
                on_off_i[i*V+v]                  = onoff[i][v][0];
            end
    endtask

    task automatic model_reset();
        for (int i = 0; i < P; i++) begin
            m_in_ptr[i] = 0; m_out_ptr[i] = 0;
        end
    endtask

    // Winner = eligible candidate at the smallest forward distance from the pointer.
    task automatic predict();
        int w1 [P];
        int best_d, d, win;
        e_vsel = '0; e_vc = '0; e_xbv = '0; e_xbs = '0;
        for (int i = 0; i < P; i++) begin
            w1[i] = -1; best_d = 1000;
            for (int v = 0; v < V; v++) begin
                if (req[i][v] != 0 && oport[i][v] < P && onoff[oport[i][v]][dvc[i][v]] != 0) begin
                    d = (v - m_in_ptr[i] + V) % V;
                    if (d < best_d) begin best_d = d; w1[i] = v; end
                end
            end
        end
        for (int op = 0; op < P; op++) begin
            win = -1; best_d = 1000;
            for (int i = 0; i < P; i++) begin
                if (w1[i] >= 0 && oport[i][w1[i]] == op) begin
                    d = (i - m_out_ptr[op] + P) % P;
                    if (d < best_d) begin best_d = d; win = i; end
                end
            end
            if (win >= 0) begin
                e_xbv[op]            = 1'b1;
                e_xbs[op*PW +: PW]   = PW'(win);
                e_vsel[win]          = 1'b1;
                e_vc[win*VW +: VW]   = VW'(w1[win]);
                m_out_ptr[op]        = (win + 1) % P;
                m_in_ptr[win]        = (w1[win] + 1) % V;
            end
        end
    endtask

    // Apply current tables, advance one edge, compare all outputs with the model.
    task automatic step();
        pack();
        predict();
        @(posedge clk);
        #1;
        chk("valid_sel", 32'(valid_sel_o), 32'(e_vsel));
        chk("vc_sel",    32'(vc_sel_o),    32'(e_vc));
        chk("xb_valid",  32'(xb_valid_o),  32'(e_xbv));
        chk("xb_sel",    32'(xb_sel_o),    32'(e_xbs));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_vsel"}, 32'(valid_sel_o), 32'd0);
        chk({name, "_vc"},   32'(vc_sel_o),    32'd0);
        chk({name, "_xbv"},  32'(xb_valid_o),  32'd0);
        chk({name, "_xbs"},  32'(xb_sel_o),    32'd0);
    endtask

    // Mid-cycle asynchronous reset; called right after a sampling point.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk_all_zero("async_rst");
        model_reset();
        clear_inputs();
        pack();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        model_reset();

        // Reset held with every VC requesting output 2
        for (int i = 0; i < P; i++)
            for (int v = 0; v < V; v++) begin
                req[i][v] = 1; oport[i][v] = 2; dvc[i][v] = 0; onoff[i][v] = 1;
            end
        pack();
        @(posedge clk); @(posedge clk); #1;
        chk_all_zero("hold_rst");
        rst = 1'b1;
        step();
        chk("rel_vsel", 32'(valid_sel_o), 32'h01);
        chk("rel_xbv",  32'(xb_valid_o),  32'h04);
        chk("rel_xbs",  32'(xb_sel_o),    32'h0);
        chk("rel_vc",   32'(vc_sel_o),    32'h0);

        // Single request: ip3 VC1 -> output 4
        do_reset();
        req[3][1] = 1; oport[3][1] = 4; dvc[3][1] = 0; onoff[4][0] = 1;
        step();
        chk("single_vsel", 32'(valid_sel_o), 32'h08);
        chk("single_vc",   32'(vc_sel_o),    32'h08);
        chk("single_xbv",  32'(xb_valid_o),  32'h10);
        chk("single_xbs",  32'(xb_sel_o),    32'(3 << 12));

        // Output contention: ip0..2 VC0 -> output 1
        do_reset();
        for (int i = 0; i < 3; i++) begin req[i][0] = 1; oport[i][0] = 1; end
        onoff[1][0] = 1;
        begin
            int seq [4] = '{0, 1, 2, 0};
            for (int c = 0; c < 4; c++) begin
                step();
                chk("oc_xbs1", 32'(xb_sel_o[5:3]), 32'(seq[c]));
                chk("oc_vsel", 32'(valid_sel_o),   32'(1 << seq[c]));
            end
        end

        // Input contention: ip2 VC0 -> out0, VC1 -> out3
        do_reset();
        req[2][0] = 1; oport[2][0] = 0;
        req[2][1] = 1; oport[2][1] = 3;
        onoff[0][0] = 1; onoff[3][0] = 1;
        begin
            int vseq [3] = '{0, 1, 0};
            for (int c = 0; c < 3; c++) begin
                step();
                chk("ic_vc2", 32'(vc_sel_o[2]), 32'(vseq[c]));
                chk("ic_xbv", 32'(xb_valid_o),  (vseq[c] == 0) ? 32'h01 : 32'h08);
            end
        end

        // Flow control: ip1 VC0 -> out2 via downstream VC1
        do_reset();
        req[1][0] = 1; oport[1][0] = 2; dvc[1][0] = 1; onoff[2][1] = 0;
        step();
        chk("fc_off", 32'(valid_sel_o), 32'h0);
        onoff[2][1] = 1;
        step();
        chk("fc_on", 32'(valid_sel_o), 32'h02);
        chk("fc_on_xbs", 32'(xb_sel_o[8:6]), 32'd1);
        onoff[2][1] = 0;
        step();
        chk("fc_drop", 32'(valid_sel_o), 32'h0);

        // Parallel grants plus an out-of-range route
        do_reset();
        req[0][0] = 1; oport[0][0] = 1;
        req[4][0] = 1; oport[4][0] = 0;
        req[2][0] = 1; oport[2][0] = 7;
        onoff[1][0] = 1; onoff[0][0] = 1;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("par_vsel", 32'(valid_sel_o), 32'h11);
            chk("par_xbv",  32'(xb_valid_o),  32'h03);
        end

        // Idle: nothing requested, nothing granted
        clear_inputs();
        step();
        chk("idle_vsel", 32'(valid_sel_o), 32'h0);

        // Randomized traffic with occasional mid-run resets
        for (int c = 0; c < 600; c++) begin
            if (c % 97 == 50) do_reset();
            for (int i = 0; i < P; i++)
                for (int v = 0; v < V; v++) begin
                    req[i][v]   = ($urandom_range(0, 3) != 0) ? 1 : 0;
                    oport[i][v] = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
                    dvc[i][v]   = $urandom_range(0, 1);
                    onoff[i][v] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                end
            step();
            chk("inv_count", 32'($countones(valid_sel_o)), 32'($countones(xb_valid_o)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
